mem_test_seq: RTL and testbench

- Parametrised, script-driven memory test sequencer that generalises the on-board BRAM test fixture. It drives the write and read ports of a memory under test (bram, bram4k, alloc) from a script table and compares read data against masked expectations.
- It reports run, pass and fail status plus failure diagnostics for LED or host readout.
- Adds runtime script loading, a repeat count, and a start/restart handshake.

---
 rtl/mem_test_seq.sv | 175 +++++++++++++++++
 tb/tb_mem_test_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_seq.sv
// mem_test_seq: script-driven memory test sequencer. One script entry per
// cycle drives the write/read ports of a memory under test and masks-compares
// the returned read data, reporting pass/fail status and first-failure details.
// Latency: memory outputs are combinational from the current entry; status and
// diagnostics are registered. No backpressure: one step executes every RUN cycle.
// Ports: i_clk/i_rst clock and sync reset; i_start run/restart pulse;
//   i_sc_* script write port; o_wr/o_waddr/o_wdata and o_rd/o_raddr/i_rdata
//   memory under test; o_running/o_passed/o_failed status; o_fail_* first
//   mismatch diagnostics; o_pass_cnt saturating completed-pass counter.
// Entry layout, MSB to LSB: wr, waddr, wdata, rd, raddr, expect, mask, last,
//   halt, next.
module mem_test_seq #(
  parameter int    ADDR_SZ   = 8,
  parameter int    DATA_SZ   = 16,
  parameter int    STEP_SZ   = 4,
  parameter int    SETTLE    = 64,
  parameter int    REPEAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_start,
  input  logic                                     i_sc_we,
  input  logic [STEP_SZ-1:0]                       i_sc_addr,
  input  logic [3+2*ADDR_SZ+3*DATA_SZ+STEP_SZ:0]   i_sc_data,
  output logic                                     o_wr,
  output logic [ADDR_SZ-1:0]                       o_waddr,
  output logic [DATA_SZ-1:0]                       o_wdata,
  output logic                                     o_rd,
  output logic [ADDR_SZ-1:0]                       o_raddr,
  input  logic [DATA_SZ-1:0]                       i_rdata,
  output logic                                     o_running,
  output logic                                     o_passed,
  output logic                                     o_failed,
  output logic [STEP_SZ-1:0]                       o_fail_step,
  output logic [DATA_SZ-1:0]                       o_fail_got,
  output logic [DATA_SZ-1:0]                       o_fail_exp,
  output logic [15:0]                              o_pass_cnt
);

  // Four single-bit fields (wr, rd, last, halt) plus the multi-bit fields.
  localparam int ENTRY_SZ  = 4 + 2*ADDR_SZ + 3*DATA_SZ + STEP_SZ;
  localparam int NUM_STEPS = 2**STEP_SZ;
  localparam int SC_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PASS   = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  typedef struct packed {
    logic               wr;
    logic [ADDR_SZ-1:0] waddr;
    logic [DATA_SZ-1:0] wdata;
    logic               rd;
    logic [ADDR_SZ-1:0] raddr;
    logic [DATA_SZ-1:0] exp_data;
    logic [DATA_SZ-1:0] mask;
    logic               last;
    logic               halt;
    logic [STEP_SZ-1:0] nxt;
  } entry_t;

  logic [ENTRY_SZ-1:0] script [NUM_STEPS] = '{default: '0};

  logic [2:0]         state;
  logic [STEP_SZ-1:0] step;
  logic [SC_W-1:0]    settle_cnt;
  logic [15:0]        pass_cnt;
  logic [STEP_SZ-1:0] fail_step;
  logic [DATA_SZ-1:0] fail_got;
  logic [DATA_SZ-1:0] fail_exp;

  entry_t      cur;
  logic        in_run;
  logic        mismatch;
  logic [15:0] cnt_inc;
  logic        done_reps;
  logic        script_open;

  assign cur    = entry_t'(script[step]);
  assign in_run = (state == S_RUN);

  // A zero mask disables the compare by construction of the masked XOR.
  assign mismatch = in_run && (((i_rdata ^ cur.exp_data) & cur.mask) != '0);

  assign cnt_inc   = (pass_cnt == 16'hFFFF) ? pass_cnt : pass_cnt + 16'd1;
  assign done_reps = (REPEAT != 0) && (cnt_inc == 16'(REPEAT));

  // The script is frozen while a test is in flight.
  assign script_open = (state == S_IDLE) || (state == S_PASS) || (state == S_FAIL);

  always_ff @(posedge i_clk) begin
    if (i_sc_we && script_open) begin
      script[i_sc_addr] <= i_sc_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      step       <= '0;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      fail_step  <= '0;
      fail_got   <= '0;
      fail_exp   <= '0;
    end else begin
      case (state)
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_RUN;
            step  <= '0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_RUN: begin
          // Mismatch wins over halt and last; halt wins over last.
          if (mismatch) begin
            state     <= S_FAIL;
            fail_step <= step;
            fail_got  <= i_rdata;
            fail_exp  <= cur.exp_data;
          end else if (cur.halt) begin
            state <= S_PASS;
          end else if (cur.last) begin
            pass_cnt <= cnt_inc;
            step     <= '0;
            if (done_reps) state <= S_PASS;
          end else begin
            step <= cur.nxt;
          end
        end
        default: begin
          // IDLE, PASS and FAIL all (re)start the same way.
          if (i_start) begin
            state      <= S_SETTLE;
            settle_cnt <= SC_W'(SETTLE - 1);
            step       <= '0;
            pass_cnt   <= '0;
            fail_step  <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    o_wr    = 1'b0;
    o_waddr = '0;
    o_wdata = '0;
    o_rd    = 1'b0;
    o_raddr = '0;
    if (in_run) begin
      o_wr    = cur.wr;
      o_waddr = cur.waddr;
      o_wdata = cur.wdata;
      o_rd    = cur.rd;
      o_raddr = cur.raddr;
    end
  end

  assign o_running   = (state == S_SETTLE) || in_run;
  assign o_passed    = (state == S_PASS);
  assign o_failed    = (state == S_FAIL);
  assign o_fail_step = fail_step;
  assign o_fail_got  = fail_got;
  assign o_fail_exp  = fail_exp;
  assign o_pass_cnt  = pass_cnt;

endmodule

// File: tb/tb_mem_test_seq.sv
// Bench for mem_test_seq: three sequencers (REPEAT 1, 3 and 0) each attached
// to a 1-cycle-latency memory. Expected results come from a step-level model
// of the script and are queued at start; a monitor pops them when status rises.
module tb_mem_test_seq;
  localparam int A = 8, D = 16, S = 4, SET = 64, NI = 3, NSTEP = 16;

  typedef struct packed {
    logic wr; logic [7:0] waddr; logic [15:0] wdata;
    logic rd; logic [7:0] raddr; logic [15:0] exp_v; logic [15:0] mask;
    logic last; logic halt; logic [3:0] nxt;
  } ent_t;

  typedef struct {
    int inst; logic passed; logic failed; logic [3:0] fstep;
    logic [15:0] fgot; logic [15:0] fexp; logic [15:0] pcnt; int lat;
  } res_t;

  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst [NI], start [NI], sc_we [NI];
  logic [3:0]  sc_addr [NI];
  logic [71:0] sc_data [NI];
  logic        wr [NI], rd [NI], running [NI], passed [NI], failed [NI];
  logic [7:0]  waddr [NI], raddr [NI];
  logic [15:0] wdata [NI], rdata [NI], fgot [NI], fexp [NI], pcnt [NI];
  logic [3:0]  fstep [NI];
  logic        mem_clr;

  int total = 0, bad = 0;
  int start_cyc [NI];
  int rise_cnt [NI];
  logic prev_st [NI];
  int settle_viol = 0;
  res_t sbq [$];
  ent_t scr [NI][NSTEP];
  logic [15:0] snap_m [256];
  logic [15:0] snap_q;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [15:0] mem [256];
    logic [15:0] rd_q;
    mem_test_seq #(.ADDR_SZ(A), .DATA_SZ(D), .STEP_SZ(S), .SETTLE(SET),
                   .REPEAT(g == 0 ? 1 : (g == 1 ? 3 : 0)), .INIT_FILE("")) dut (
      .i_clk(clk), .i_rst(rst[g]), .i_start(start[g]),
      .i_sc_we(sc_we[g]), .i_sc_addr(sc_addr[g]), .i_sc_data(sc_data[g]),
      .o_wr(wr[g]), .o_waddr(waddr[g]), .o_wdata(wdata[g]),
      .o_rd(rd[g]), .o_raddr(raddr[g]), .i_rdata(rd_q),
      .o_running(running[g]), .o_passed(passed[g]), .o_failed(failed[g]),
      .o_fail_step(fstep[g]), .o_fail_got(fgot[g]), .o_fail_exp(fexp[g]),
      .o_pass_cnt(pcnt[g]));
    assign rdata[g] = rd_q;
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int a = 0; a < 256; a++) mem[a] <= '0;
        rd_q <= '0;
      end else begin
        if (rd[g]) rd_q <= mem[raddr[g]];
        if (wr[g]) mem[waddr[g]] <= wdata[g];
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic int rep_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  function automatic ent_t mk(input logic w, input logic [7:0] wa, input logic [15:0] wd,
                              input logic r, input logic [7:0] ra, input logic [15:0] ex,
                              input logic [15:0] mk_, input logic l, input logic h,
                              input logic [3:0] n);
    ent_t e;
    e = '{wr:w, waddr:wa, wdata:wd, rd:r, raddr:ra, exp_v:ex, mask:mk_, last:l, halt:h, nxt:n};
    return e;
  endfunction

  function automatic logic [127:0] outs(input int i);
    return {39'b0, wr[i], rd[i], running[i], passed[i], failed[i], fstep[i],
            fgot[i], fexp[i], pcnt[i], waddr[i], wdata[i], raddr[i]};
  endfunction

  task automatic snap(input int i);
    case (i)
      0: begin snap_m = g_dut[0].mem; snap_q = g_dut[0].rd_q; end
      1: begin snap_m = g_dut[1].mem; snap_q = g_dut[1].rd_q; end
      default: begin snap_m = g_dut[2].mem; snap_q = g_dut[2].rd_q; end
    endcase
  endtask

  // Step-level model: walks the script, reading data one step late, and
  // stops at the first masked mismatch, a halt, or the required pass count.
  function automatic res_t model(input int i, input int rep, input int maxc);
    res_t r; logic [15:0] m [256]; logic [15:0] q, nq; int k, n, cnt; ent_t e;
    m = snap_m; q = snap_q; k = 0; n = 0; cnt = 0;
    r = '{inst:i, passed:0, failed:0, fstep:0, fgot:0, fexp:0, pcnt:0, lat:-1};
    while (n < maxc && r.lat < 0) begin
      e = scr[i][k];
      n++;
      if (((q ^ e.exp_v) & e.mask) != 16'h0) begin
        r.failed = 1; r.fstep = 4'(k); r.fgot = q; r.fexp = e.exp_v; r.lat = SET + n;
      end else begin
        nq = e.rd ? m[e.raddr] : q;
        if (e.wr) m[e.waddr] = e.wdata;
        q = nq;
        if (e.halt) begin
          r.passed = 1; r.lat = SET + n;
        end else if (e.last) begin
          if (cnt < 65535) cnt++;
          k = 0;
          if (rep != 0 && cnt == rep) begin r.passed = 1; r.lat = SET + n; end
        end else begin
          k = int'(e.nxt);
        end
      end
    end
    r.pcnt = 16'(cnt);
    return r;
  endfunction

  task automatic wr_ent(input int i, input int k, input ent_t e, input bit upd);
    @(negedge clk);
    sc_we[i] = 1; sc_addr[i] = 4'(k); sc_data[i] = e;
    @(negedge clk);
    sc_we[i] = 0;
    if (upd) scr[i][k] = e;
  endtask

  task automatic load_golden(input int i);
    wr_ent(i, 0, mk(1, 8'hFF, 16'hBE11, 0, 0, 0, 0, 0, 0, 1), 1);
    wr_ent(i, 1, mk(1, 8'h95, 16'hC0DE, 0, 0, 0, 0, 0, 0, 2), 1);
    wr_ent(i, 2, mk(0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 3), 1);
    wr_ent(i, 3, mk(0, 0, 0, 1, 8'h95, 16'hBE11, 16'hFFFF, 0, 0, 4), 1);
    wr_ent(i, 4, mk(0, 0, 0, 0, 0, 16'hC0DE, 16'hFFFF, 1, 0, 0), 1);
    for (int k = 5; k < NSTEP; k++) wr_ent(i, k, '0, 1);
  endtask

  task automatic do_start(input int i);
    @(negedge clk);
    start[i] = 1;
    @(posedge clk);
    #1 start_cyc[i] = cyc;
    chk("start_clear", {passed[i], failed[i], fstep[i], fgot[i], fexp[i], pcnt[i]}, 0);
    chk("running_on", running[i], 1);
    @(negedge clk);
    start[i] = 0;
  endtask

  task automatic run_test(input int i);
    res_t r; bit got;
    snap(i);
    r = model(i, rep_of(i), 1000);
    sbq.push_back(r);
    do_start(i);
    got = 0;
    for (int t = 0; t < SET + 200 && !got; t++) begin
      @(negedge clk);
      if (passed[i] || failed[i]) got = 1;
    end
    chk("status_seen", got, 1);
    @(negedge clk);
    chk("mem_idle", {wr[i], rd[i], waddr[i], wdata[i], raddr[i]}, 0);
  endtask

  task automatic gen_rand(input int i);
    logic [15:0] pm [256]; logic [15:0] pq, nq; int l, h; ent_t e;
    snap(i);
    pm = snap_m; pq = snap_q;
    l = $urandom_range(3, 15);
    h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l - 1) : -1;
    for (int k = 0; k < NSTEP; k++) begin
      e = '0;
      if (k <= l) begin
        e.wr = 1'($urandom_range(0, 1)); e.waddr = 8'($urandom_range(0, 3));
        e.wdata = 16'($urandom);
        e.rd = 1'($urandom_range(0, 1)); e.raddr = 8'($urandom_range(0, 3));
        e.mask = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
        e.exp_v = pq ^ (($urandom_range(0, 7) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
        e.last = (k == l); e.halt = (k == h); e.nxt = 4'(k + 1);
        nq = e.rd ? pm[e.raddr] : pq;
        if (e.wr) pm[e.waddr] = e.wdata;
        pq = nq;
      end
      wr_ent(i, k, e, 1);
    end
  endtask

  // Monitor: pop one expected result per status rise and compare everything.
  always @(negedge clk) begin : mon
    logic st; res_t r;
    for (int i = 0; i < NI; i++) begin
      if (running[i] === 1'b1 && (cyc - start_cyc[i]) < SET && (wr[i] || rd[i]))
        settle_viol++;
      st = passed[i] | failed[i];
      if (st === 1'b1 && prev_st[i] !== 1'b1) begin
        rise_cnt[i]++;
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          r = sbq.pop_front();
          chk("sb_inst", 128'(i), 128'(r.inst));
          chk("passed", passed[i], r.passed);
          chk("failed", failed[i], r.failed);
          chk("fail_step", fstep[i], r.fstep);
          chk("fail_got", fgot[i], r.fgot);
          chk("fail_exp", fexp[i], r.fexp);
          chk("pass_cnt", pcnt[i], r.pcnt);
          chk("latency", 128'(cyc - start_cyc[i]), 128'(r.lat));
          chk("running_off", running[i], 0);
        end
      end
      prev_st[i] = st;
    end
  end

  initial begin
    res_t r; int el;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1; start[i] = 0; sc_we[i] = 0; sc_addr[i] = 0; sc_data[i] = 0;
      start_cyc[i] = 0; rise_cnt[i] = 0; prev_st[i] = 0;
    end
    mem_clr = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst[i] = 0;
    mem_clr = 0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("reset_outs", outs(i), 0);

    // REPEAT=1: golden, corrupted expect, mask, halt, mismatch on last step.
    load_golden(0);
    run_test(0);
    wr_ent(0, 3, mk(0, 0, 0, 1, 8'h95, 16'hBE10, 16'hFFFF, 0, 0, 4), 1);
    run_test(0);
    chk("fail_step_3", fstep[0], 3);
    wr_ent(0, 3, mk(0, 0, 0, 1, 8'h95, 16'h0011, 16'h00FF, 0, 0, 4), 1);
    run_test(0);
    chk("mask_pass", passed[0], 1);
    wr_ent(0, 2, mk(0, 0, 0, 1, 8'hFF, 0, 0, 0, 1, 3), 1);
    run_test(0);
    chk("halt_cnt", pcnt[0], 0);
    wr_ent(0, 2, mk(0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 3), 1);
    wr_ent(0, 4, mk(0, 0, 0, 0, 0, 16'hC0DF, 16'hFFFF, 1, 0, 0), 1);
    run_test(0);
    chk("last_mismatch_cnt", pcnt[0], 0);

    // REPEAT=3: golden reaches three passes and PASS is entered once.
    load_golden(1);
    run_test(1);
    repeat (30) @(negedge clk);
    chk("rep3_cnt", pcnt[1], 3);
    chk("rep3_single_rise", rise_cnt[1], 1);

    // REPEAT=0: continuous run, frozen script, reset mid-run.
    load_golden(2);
    snap(2);
    do_start(2);
    repeat (SET + 50) @(negedge clk);
    el = cyc - start_cyc[2];
    r = model(2, 0, el - SET);
    chk("rep0_cnt", pcnt[2], r.pcnt);
    chk("rep0_running", running[2], 1);
    wr_ent(2, 3, mk(0, 0, 0, 1, 8'h95, 16'hBE10, 16'hFFFF, 0, 0, 4), 0);
    repeat (30) @(negedge clk);
    chk("run_write_ignored", {running[2], failed[2], passed[2]}, 3'b100);
    @(negedge clk);
    rst[2] = 1;
    @(posedge clk);
    #1 chk("reset_mid_run", outs(2), 0);
    @(negedge clk);
    rst[2] = 0;
    wr_ent(2, 4, mk(0, 0, 0, 0, 0, 16'hC0DE, 16'hFFFF, 0, 1, 0), 1);
    run_test(2);
    chk("script_kept", passed[2], 1);

    // Randomised scripts on the terminating sequencers.
    for (int t = 0; t < 12; t++) begin
      gen_rand(t % 2);
      run_test(t % 2);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("settle_quiet", settle_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
